product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
// - Downstream stage of the combinational array multiplier: consumes its BIT_WIDTH-bit
//   products one per beat and sums a frame of LEN products into an ACC_WIDTH accumulator.
// - Emits one frame sum per frame over a valid/ready handshake, plus a sticky overflow flag.
// - Turns the multiplier into a dot-product / MAC datapath without changing the multiplier.
// PARAMETERS
// - BIT_WIDTH   8   product width; matches multiplier result width, already mod 2^BIT_WIDTH
// - ACC_WIDTH   16  accumulator / out_data width; must be >= BIT_WIDTH
// - CNT_WIDTH   4   frame length counter width; max frame = 2^CNT_WIDTH beats
// PORTS
// - clk          in   1          rising-edge clock
// - rst          in   1          asynchronous, active-high reset
// - clear        in   1          synchronous abort: drop current frame, return to IDLE
// - len          in   CNT_WIDTH  products per frame; sampled on first beat; 0 means 2^CNT_WIDTH
// - in_valid     in   1          in_data valid
// - in_ready     out  1          block accepts in_data this cycle
// - in_data      in   BIT_WIDTH  product from multiplier, unsigned
// - out_valid    out  1          out_data/out_overflow hold a completed frame
// - out_ready    in   1          consumer takes the frame
// - out_data     out  ACC_WIDTH  frame sum
// - out_overflow out  1          a carry left ACC_WIDTH during this frame
// BEHAVIOUR
// - Beat accepted when in_valid && in_ready; frame delivered when out_valid && out_ready.
// - Reset: state=IDLE, acc=0, cnt=0, len_q=0, ovf=0; in_ready=1, out_valid=0, out_data=0,
//   out_overflow=0.
// - States: IDLE, ACCUM, HOLD. in_ready = (state != HOLD); out_valid = (state == HOLD).
// - IDLE: on accepted beat: acc<=zext(in_data), cnt<=1, len_q<=len (0 -> 2^CNT_WIDTH),
//   ovf<=0; go HOLD if effective len==1, else ACCUM. No beat: stay, registers unchanged.
// - ACCUM: on accepted beat: acc<=acc+zext(in_data), cnt<=cnt+1; go HOLD when cnt+1==len_q.
//   in_valid low: hold all state, no timeout.
// - cnt and len_q are CNT_WIDTH+1 bits internally so len=0 (2^CNT_WIDTH beats) is exact.
// - Arithmetic: unsigned, ACC_WIDTH+1-bit sum; bit ACC_WIDTH set -> ovf<=1 (sticky per frame);
//   acc keeps low ACC_WIDTH bits (wrap) unless SATURATE_EN.
// - HOLD: out_data=acc, out_overflow=ovf stable until handshake; in_ready=0 (back-pressure).
//   On out_ready: go IDLE; out_data keeps last value, out_valid drops next cycle.
// - Latency: last input beat accepted at cycle N -> out_valid=1 at N+1. Min frame period
//   len+1 cycles with out_ready held high (one HOLD bubble per frame).
// - clear has priority over every handshake in the same cycle: state<=IDLE, acc<=0,
//   cnt<=0, ovf<=0; the concurrent input beat and any pending HOLD frame are discarded.
// - rst asserted mid-frame or in HOLD: immediate return to reset values; frame lost.
// - len changes after the first beat of a frame have no effect until the next frame.
// CONFIGURATION
// - SATURATE_EN defined: on a carry out of ACC_WIDTH, acc<={ACC_WIDTH{1'b1}} and stays
//   there for the rest of the frame; ovf still set.
// - SATURATE_EN undefined: acc wraps modulo 2^ACC_WIDTH; ovf set. Default build: undefined.
// TESTING
// - Reset then idle: rst pulse -> in_ready=1, out_valid=0, out_data=0, out_overflow=0.
// - len=4, beats 3,5,7,9, out_ready=1 -> out_data=24, overflow=0, out_valid one cycle after
//   4th beat, in_ready=0 during that cycle.
// - len=0 (16 beats), each 8'hFF, ACC_WIDTH=16 -> out_data=16'h0FF0, overflow=0;
//   in_valid gapped randomly -> same result.
// - ACC_WIDTH=8, len=2, beats 200,100 -> wrap: out_data=44, overflow=1;
//   SATURATE_EN: out_data=255, overflow=1.
// - Back-pressure: frame done, out_ready=0 for 5 cycles -> out_data stable, in_valid beats
//   not accepted; out_ready=1 -> next frame starts from 0 with ovf cleared.
// - clear on 3rd beat of len=4 frame (and clear in HOLD with out_ready=1) -> IDLE, no
//   out_valid; next frame len=1 beat 7 -> out_data=7.

Source files
------------

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer and the product accumulator.
// Carries the input beat stream, the frame result stream and the frame controls.
interface product_accumulator_if #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 4
);
    logic                 clear;
    logic [CNT_WIDTH-1:0] len;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_overflow;

    modport master (
        output clear, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_overflow
    );

    modport slave (
        input  clear, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums frames of LEN multiplier products and hands each frame sum downstream with a sticky overflow flag.
// Optional feature macro: SATURATE_EN (saturate the accumulator on carry instead of wrapping).
module product_accumulator #(
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    product_accumulator_if.slave  bus
);
    localparam int unsigned LW = CNT_WIDTH + 1;
    localparam int unsigned SW = ACC_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        len_q, len_d;
    logic                 ovf_q, ovf_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;

    logic                 beat_c;
    logic [LW-1:0]        len_eff_c;
    logic [LW-1:0]        cnt_inc_c;
    logic [SW-1:0]        sum_c;
    logic                 carry_c;
    logic [ACC_WIDTH-1:0] acc_next_c;

    // Datapath: beat qualifier, effective frame length and the widened accumulate.
    always_comb begin
        beat_c    = bus.in_valid && in_ready_q;
        len_eff_c = (bus.len == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : LW'(bus.len);
        cnt_inc_c = cnt_q + LW'(1);
        sum_c     = SW'(acc_q) + SW'(bus.in_data);
        carry_c   = sum_c[ACC_WIDTH];
`ifdef SATURATE_EN
        acc_next_c = carry_c ? {ACC_WIDTH{1'b1}} : sum_c[ACC_WIDTH-1:0];
`else
        acc_next_c = sum_c[ACC_WIDTH-1:0];
`endif
    end

    // Next-state and registered-output logic; clear overrides every handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        if (bus.clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_c) begin
                        acc_d   = ACC_WIDTH'(bus.in_data);
                        cnt_d   = LW'(1);
                        len_d   = len_eff_c;
                        ovf_d   = 1'b0;
                        state_d = (len_eff_c == LW'(1)) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_c) begin
                        acc_d = acc_next_c;
                        cnt_d = cnt_inc_c;
                        if (carry_c) begin
                            ovf_d = 1'b1;
                        end
                        if (cnt_inc_c == len_q) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Result registers load only on HOLD entry so they stay put after the handshake.
        if ((state_d == HOLD) && (state_q != HOLD)) begin
            out_data_d = acc_d;
            out_ovf_d  = ovf_d;
        end

        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 16-bit and an 8-bit accumulator share one stimulus stream
// and are compared against an arithmetic frame-sum reference.
`timescale 1ns/1ps
module tb_product_accumulator;
    localparam int unsigned BW   = 8;
    localparam int unsigned CW   = 4;
    localparam int unsigned AW_A = 16;
    localparam int unsigned AW_B = 8;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    product_accumulator_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW_A), .CNT_WIDTH(CW)) a ();
    product_accumulator_if #(.BIT_WIDTH(BW), .ACC_WIDTH(AW_B), .CNT_WIDTH(CW)) b ();

    assign b.clear     = a.clear;
    assign b.len       = a.len;
    assign b.in_valid  = a.in_valid;
    assign b.in_data   = a.in_data;
    assign b.out_ready = a.out_ready;

    product_accumulator #(.BIT_WIDTH(BW), .ACC_WIDTH(AW_A), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst(rst), .bus(a)
    );
    product_accumulator #(.BIT_WIDTH(BW), .ACC_WIDTH(AW_B), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst(rst), .bus(b)
    );

    always #5 clk = ~clk;

    // Reference frame result: {overflow, sum} for an accumulator of width accw.
    function automatic logic [16:0] ref_frame(input int unsigned total, input int unsigned accw);
        int unsigned lim;
        int unsigned val;
        logic        ovf;
        lim = 32'd1 << accw;
        ovf = (total >= lim);
`ifdef SATURATE_EN
        val = ovf ? lim - 1 : total;
`else
        val = total % lim;
`endif
        return {ovf, 16'(val)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        a.in_valid = 1'b1;
        a.in_data  = d;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (a.in_ready === 1'b1) ok = 1'b1;
            tick();
        end
        a.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] len, input int n, input logic [7:0] dat [16],
                              input int gap_max, output bit ok, output int unsigned total);
        bit bo;
        ok    = 1'b1;
        total = 0;
        a.len = len;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            send_beat(dat[i], bo);
            ok    = ok && bo;
            total = total + 32'(dat[i]);
            if (i == 0) a.len = CW'($urandom);
        end
    endtask

    task automatic collect_frame(input int stall, output bit ok,
                                 output logic [15:0] d_a, output logic o_a,
                                 output logic [7:0] d_b, output logic o_b, output logic v_after);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (a.out_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        repeat (stall) tick();
        d_a = a.out_data;
        o_a = a.out_overflow;
        d_b = b.out_data;
        o_b = b.out_overflow;
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        v_after = a.out_valid;
    endtask

    task automatic test_reset();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        rst = 1'b1;
        a.clear = 1'b0; a.len = '0; a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        n_chk++; if (a.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", a.in_ready); else n_pass++;
        n_chk++; if (a.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a.out_valid); else n_pass++;
        n_chk++; if (a.out_data !== 16'd0) $display("FAIL reset_out_data got %0d want 0", a.out_data); else n_pass++;
        n_chk++; if (a.out_overflow !== 1'b0) $display("FAIL reset_out_overflow got %b want 0", a.out_overflow); else n_pass++;
        // Async reset while holding a frame.
        dat[0] = 8'd77;
        send_frame(4'd1, 1, dat, 0, ok, tot);
        n_chk++; if (a.out_valid !== 1'b1) $display("FAIL hold_before_rst got %b want 1", a.out_valid); else n_pass++;
        rst = 1'b1;
        #2;
        n_chk++; if (a.out_valid !== 1'b0) $display("FAIL async_rst_valid got %b want 0", a.out_valid); else n_pass++;
        n_chk++; if (a.out_data !== 16'd0) $display("FAIL async_rst_data got %0d want 0", a.out_data); else n_pass++;
        tick();
        rst = 1'b0;
        // Reset mid-frame then a fresh len=2 frame.
        dat[0] = 8'd10; dat[1] = 8'd20;
        send_frame(4'd4, 2, dat, 0, ok, tot);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        dat[0] = 8'd1; dat[1] = 8'd2;
        send_frame(4'd2, 2, dat, 0, ok, tot);
        collect_frame(0, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2)) $display("FAIL rst_midframe_timeout got %b%b want 11", ok, ok2); else n_pass++;
        n_chk++; if (da !== 16'd3) $display("FAIL rst_midframe_sum got %0d want 3", da); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        dat[0] = 8'd3; dat[1] = 8'd5; dat[2] = 8'd7; dat[3] = 8'd9;
        send_frame(4'd4, 4, dat, 0, ok, tot);
        n_chk++; if (a.out_valid !== 1'b1) $display("FAIL basic_latency_valid got %b want 1", a.out_valid); else n_pass++;
        n_chk++; if (a.in_ready !== 1'b0) $display("FAIL basic_hold_in_ready got %b want 0", a.in_ready); else n_pass++;
        collect_frame(0, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2)) $display("FAIL basic_timeout got %b%b want 11", ok, ok2); else n_pass++;
        n_chk++; if (da !== 16'd24) $display("FAIL basic_sum16 got %0d want 24", da); else n_pass++;
        n_chk++; if (oa !== 1'b0) $display("FAIL basic_ovf16 got %b want 0", oa); else n_pass++;
        n_chk++; if (db !== 8'd24) $display("FAIL basic_sum8 got %0d want 24", db); else n_pass++;
        n_chk++; if (va !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", va); else n_pass++;
    endtask

    task automatic test_len0();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        logic [16:0] rb;
        for (int i = 0; i < 16; i++) dat[i] = 8'hFF;
        rb = ref_frame(32'd4080, AW_B);
        for (int g = 0; g < 2; g++) begin
            send_frame(4'd0, 16, dat, g * 3, ok, tot);
            collect_frame(0, ok2, da, oa, db, ob, va);
            n_chk++; if (!(ok && ok2)) $display("FAIL len0_timeout gap%0d got %b%b want 11", g, ok, ok2); else n_pass++;
            n_chk++; if (da !== 16'h0FF0) $display("FAIL len0_sum16 gap%0d got %h want 0ff0", g, da); else n_pass++;
            n_chk++; if (oa !== 1'b0) $display("FAIL len0_ovf16 gap%0d got %b want 0", g, oa); else n_pass++;
            n_chk++; if ({ob, db} !== {rb[16], rb[7:0]}) $display("FAIL len0_res8 gap%0d got %b/%h want %b/%h", g, ob, db, rb[16], rb[7:0]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        logic [7:0]  exp_b;
`ifdef SATURATE_EN
        exp_b = 8'd255;
`else
        exp_b = 8'd44;
`endif
        dat[0] = 8'd200; dat[1] = 8'd100;
        send_frame(4'd2, 2, dat, 1, ok, tot);
        collect_frame(2, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2)) $display("FAIL wrap_timeout got %b%b want 11", ok, ok2); else n_pass++;
        n_chk++; if (db !== exp_b) $display("FAIL wrap_sum8 got %0d want %0d", db, exp_b); else n_pass++;
        n_chk++; if (ob !== 1'b1) $display("FAIL wrap_ovf8 got %b want 1", ob); else n_pass++;
        n_chk++; if (da !== 16'd300 || oa !== 1'b0) $display("FAIL wrap_res16 got %0d/%b want 300/0", da, oa); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        dat[0] = 8'd200; dat[1] = 8'd100;
        send_frame(4'd2, 2, dat, 0, ok, tot);
        a.out_ready = 1'b0;
        a.in_valid  = 1'b1;
        a.in_data   = 8'h55;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (a.out_valid !== 1'b1 || a.in_ready !== 1'b0) $display("FAIL bp_hs cyc%0d got v%b r%b want v1 r0", i, a.out_valid, a.in_ready); else n_pass++;
            n_chk++; if (a.out_data !== 16'd300) $display("FAIL bp_stable cyc%0d got %0d want 300", i, a.out_data); else n_pass++;
            tick();
        end
        a.in_valid  = 1'b0;
        a.out_ready = 1'b1;
        tick();
        a.out_ready = 1'b0;
        n_chk++; if (a.out_valid !== 1'b0) $display("FAIL bp_release got %b want 0", a.out_valid); else n_pass++;
        dat[0] = 8'd7;
        send_frame(4'd1, 1, dat, 0, ok, tot);
        collect_frame(0, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2)) $display("FAIL bp_next_timeout got %b%b want 11", ok, ok2); else n_pass++;
        n_chk++; if (da !== 16'd7 || db !== 8'd7) $display("FAIL bp_next_sum got %0d/%0d want 7/7", da, db); else n_pass++;
        n_chk++; if (ob !== 1'b0) $display("FAIL bp_next_ovf8 got %b want 0", ob); else n_pass++;
    endtask

    task automatic test_clear();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        dat[0] = 8'd1; dat[1] = 8'd2;
        send_frame(4'd4, 2, dat, 0, ok, tot);
        a.clear = 1'b1; a.in_valid = 1'b1; a.in_data = 8'd100;
        tick();
        a.clear = 1'b0; a.in_valid = 1'b0;
        repeat (3) tick();
        n_chk++; if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) $display("FAIL clear_mid got v%b r%b want v0 r1", a.out_valid, a.in_ready); else n_pass++;
        dat[0] = 8'd7;
        send_frame(4'd1, 1, dat, 0, ok, tot);
        collect_frame(0, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2) || da !== 16'd7) $display("FAIL clear_mid_next got %0d ok%b%b want 7", da, ok, ok2); else n_pass++;
        // Clear while a completed frame is held, with out_ready also high.
        dat[0] = 8'd9;
        send_frame(4'd1, 1, dat, 0, ok, tot);
        a.clear = 1'b1; a.out_ready = 1'b1;
        tick();
        a.clear = 1'b0; a.out_ready = 1'b0;
        n_chk++; if (a.out_valid !== 1'b0) $display("FAIL clear_hold got %b want 0", a.out_valid); else n_pass++;
        dat[0] = 8'd7;
        send_frame(4'd1, 1, dat, 0, ok, tot);
        collect_frame(0, ok2, da, oa, db, ob, va);
        n_chk++; if (!(ok && ok2) || da !== 16'd7 || oa !== 1'b0) $display("FAIL clear_hold_next got %0d/%b want 7/0", da, oa); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d;
        int unsigned fsum;
        logic        exp_rdy;
        logic [16:0] rb;
        a.len = 4'd3; a.out_ready = 1'b1; a.in_valid = 1'b1;
        fsum = 0;
        for (int c = 0; c < 12; c++) begin
            d = 8'($urandom_range(0, 255));
            a.in_data = d;
            exp_rdy = ((c % 4) != 3);
            n_chk++; if (a.in_ready !== exp_rdy || a.out_valid !== !exp_rdy) $display("FAIL b2b_pattern cyc%0d got r%b v%b want r%b v%b", c, a.in_ready, a.out_valid, exp_rdy, !exp_rdy); else n_pass++;
            if (!exp_rdy) begin
                rb = ref_frame(fsum, AW_B);
                n_chk++; if (a.out_data !== 16'(fsum) || b.out_data !== rb[7:0]) $display("FAIL b2b_sum cyc%0d got %0d/%0d want %0d/%0d", c, a.out_data, b.out_data, fsum, rb[7:0]); else n_pass++;
                fsum = 0;
            end else begin
                fsum = fsum + 32'(d);
            end
            tick();
        end
        a.in_valid = 1'b0; a.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  dat [16];
        bit          ok, ok2;
        int unsigned tot;
        int          n;
        logic [3:0]  len;
        logic [15:0] da; logic [7:0] db; logic oa, ob, va;
        logic [16:0] ra, rb;
        for (int f = 0; f < 25; f++) begin
            len = CW'($urandom);
            n = (len == 4'd0) ? 16 : int'(len);
            for (int i = 0; i < 16; i++) dat[i] = 8'($urandom);
            send_frame(len, n, dat, 2, ok, tot);
            collect_frame($urandom_range(0, 3), ok2, da, oa, db, ob, va);
            ra = ref_frame(tot, AW_A);
            rb = ref_frame(tot, AW_B);
            n_chk++; if (!(ok && ok2)) $display("FAIL rand_timeout f%0d got %b%b want 11", f, ok, ok2); else n_pass++;
            n_chk++; if ({oa, da} !== ra) $display("FAIL rand_res16 f%0d got %b/%0d want %b/%0d", f, oa, da, ra[16], ra[15:0]); else n_pass++;
            n_chk++; if ({ob, db} !== {rb[16], rb[7:0]}) $display("FAIL rand_res8 f%0d got %b/%0d want %b/%0d", f, ob, db, rb[16], rb[7:0]); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
